// File: rtl/mem_if_pkg.sv
// Shared definitions for the CPU-side memory transaction interface:
// access-width codes, responder FSM states and the byte-lane helpers that
// map MSB-justified bus data onto big-endian 64-bit storage words.
package mem_if_pkg;

  localparam logic [1:0] RAM_WIDTH8  = 2'd0;
  localparam logic [1:0] RAM_WIDTH16 = 2'd1;
  localparam logic [1:0] RAM_WIDTH32 = 2'd2;
  localparam logic [1:0] RAM_WIDTH64 = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Byte offset inside the 64-bit word after aligning down to the access width.
  function automatic logic [2:0] align_offset(logic [1:0] width, logic [2:0] off);
    logic [2:0] res;
    case (width)
      RAM_WIDTH8:  res = off;
      RAM_WIDTH16: res = {off[2:1], 1'b0};
      RAM_WIDTH32: res = {off[2], 2'b00};
      default:     res = 3'd0;
    endcase
    return res;
  endfunction

  // Byte enables: bit 7 is lane 0 (bits 63:56), bit 0 is lane 7 (bits 7:0).
  function automatic logic [7:0] lane_mask(logic [1:0] width, logic [2:0] off);
    logic [2:0] o;
    logic [7:0] res;
    o = align_offset(width, off);
    case (width)
      RAM_WIDTH8:  res = 8'b1000_0000 >> o;
      RAM_WIDTH16: res = 8'b1100_0000 >> o;
      RAM_WIDTH32: res = 8'b1111_0000 >> o;
      default:     res = 8'b1111_1111;
    endcase
    return res;
  endfunction

  // Move MSB-justified write data down to the lanes it belongs to.
  function automatic logic [63:0] align_wdata(logic [63:0] data, logic [1:0] width,
                                              logic [2:0] off);
    logic [5:0] sh;
    sh = {align_offset(width, off), 3'b000};
    return data >> sh;
  endfunction

  // Lift the addressed lanes of a storage word to the MSB end, zero the rest.
  function automatic logic [63:0] extract_rdata(logic [63:0] word, logic [1:0] width,
                                                logic [2:0] off);
    logic [5:0]  sh;
    logic [63:0] keep;
    sh = {align_offset(width, off), 3'b000};
    case (width)
      RAM_WIDTH8:  keep = 64'hFF00_0000_0000_0000;
      RAM_WIDTH16: keep = 64'hFFFF_0000_0000_0000;
      RAM_WIDTH32: keep = 64'hFFFF_FFFF_0000_0000;
      default:     keep = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return (word << sh) & keep;
  endfunction

endpackage

// File: rtl/mem_resp_ram.sv
// Simple-dual-port 64-bit storage with eight byte-write enables.
// The read port is normally registered (one-cycle latency, BRAM style);
// BYPASS selects a combinational read for the single-cycle responder.
module mem_resp_ram
  import mem_if_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 10,
  parameter bit          BYPASS    = 1'b0
) (
  input  logic                 clk,
  input  logic [7:0]           we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [63:0]          wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [63:0]          rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  // Storage is deliberately not reset so it maps onto block RAM.
  logic [63:0] mem_q [0:DEPTH-1];

  // Byte-lane writes; bit i of we covers wdata[8*i+7:8*i].
  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (we[i]) begin
        mem_q[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  if (BYPASS) begin : g_bypass
    assign rdata = mem_q[raddr];
  end else begin : g_reg
    logic [63:0] rdata_q;

    // Registered read port: data for raddr appears one edge later.
    always_ff @(posedge clk) begin
      rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;
  end

endmodule

// File: rtl/mem_responder.sv
// On-chip responder for the CPU memory transaction interface. Accepts one
// read or write when ready, commits writes immediately, and pulses
// transaction_complete LATENCY cycles after the strobe cycle. Read data is
// registered into data_out on the edge that enters DONE and then held.
module mem_responder
  import mem_if_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned LATENCY   = 4
) (
  input  logic        cpu_clk,
  input  logic        rst,
  input  logic [27:0] addr,
  input  logic [1:0]  width,
  input  logic [63:0] data_in,
  input  logic        rstrobe,
  input  logic        wstrobe,
  output logic [63:0] data_out,
  output logic        transaction_complete,
  output logic        ready
);

  // Counter load value: the cycles spent in BUSY after acceptance.
  localparam logic [7:0] LOAD_VAL     = 8'(LATENCY - 1);
  localparam bit         SINGLE_CYCLE = (LATENCY == 1);
  // State entered on acceptance; with single-cycle latency BUSY is skipped.
  localparam state_e     ACCEPT_STATE = SINGLE_CYCLE ? ST_DONE : ST_BUSY;

  state_e                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic                  tc_q, tc_d;
  logic [63:0]           dout_q, dout_d;
  logic [ADDR_BITS-1:0]  word_q, word_d;
  logic [2:0]            off_q, off_d;
  logic [1:0]            width_q, width_d;
  logic                  is_rd_q, is_rd_d;

  logic                  accept_s;
  logic                  wr_en_s;
  logic                  rd_only_s;
  logic [ADDR_BITS-1:0]  word_in_s;
  logic [7:0]            ram_we_s;
  logic [63:0]           ram_wdata_s;
  logic [ADDR_BITS-1:0]  ram_raddr_s;
  logic [63:0]           ram_rdata_s;
  logic                  unused_addr_s;

  // Address bits above the storage depth alias; they are intentionally dropped.
  assign unused_addr_s = ^addr[27:ADDR_BITS+3];

  assign word_in_s = addr[ADDR_BITS+2:3];
  assign accept_s  = ready_q & (rstrobe | wstrobe);
  // A simultaneous read and write performs only the write.
  assign wr_en_s   = accept_s & wstrobe;
  assign rd_only_s = accept_s & rstrobe & ~wstrobe;

  // RAM port steering: writes commit on the accepting edge; the read address
  // follows the live bus on acceptance and the held word otherwise, so the
  // registered RAM output is valid on the edge that enters DONE.
  always_comb begin
    ram_we_s    = 8'h00;
    ram_wdata_s = align_wdata(data_in, width, addr[2:0]);
    ram_raddr_s = word_q;
    if (wr_en_s) begin
      ram_we_s = lane_mask(width, addr[2:0]);
    end else begin
      ram_we_s = 8'h00;
    end
    if (accept_s) begin
      ram_raddr_s = word_in_s;
    end else begin
      ram_raddr_s = word_q;
    end
  end

  mem_resp_ram #(
    .ADDR_BITS (ADDR_BITS),
    .BYPASS    (SINGLE_CYCLE)
  ) u_ram (
    .clk   (cpu_clk),
    .we    (ram_we_s),
    .waddr (word_in_s),
    .wdata (ram_wdata_s),
    .raddr (ram_raddr_s),
    .rdata (ram_rdata_s)
  );

  // Next-state, latency counter, captured request and registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    off_d   = off_q;
    width_d = width_q;
    is_rd_d = is_rd_q;
    dout_d  = dout_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept_s) begin
          state_d = ACCEPT_STATE;
          cnt_d   = LOAD_VAL;
          word_d  = word_in_s;
          off_d   = addr[2:0];
          width_d = width;
          is_rd_d = rd_only_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // Counting down to 1 guards against a stuck zero as well.
        if (cnt_q <= 8'd1) begin
          state_d = ST_DONE;
          cnt_d   = 8'd0;
        end else begin
          state_d = ST_BUSY;
          cnt_d   = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    // Read data capture on DONE entry; writes leave data_out untouched.
    if (SINGLE_CYCLE) begin
      if (rd_only_s) begin
        dout_d = extract_rdata(ram_rdata_s, width, addr[2:0]);
      end else begin
        dout_d = dout_q;
      end
    end else begin
      if ((state_q == ST_BUSY) && (state_d == ST_DONE) && is_rd_q) begin
        dout_d = extract_rdata(ram_rdata_s, width_q, off_q);
      end else begin
        dout_d = dout_q;
      end
    end
  end

  assign ready_d = (state_d != ST_BUSY);
  assign tc_d    = (state_d == ST_DONE);

  // State and output registers; RAM contents are not affected by reset.
  always_ff @(posedge cpu_clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      ready_q <= 1'b0;
      tc_q    <= 1'b0;
      dout_q  <= 64'd0;
      word_q  <= '0;
      off_q   <= 3'd0;
      width_q <= 2'd0;
      is_rd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      tc_q    <= tc_d;
      dout_q  <= dout_d;
      word_q  <= word_d;
      off_q   <= off_d;
      width_q <= width_d;
      is_rd_q <= is_rd_d;
    end
  end

  assign ready                = ready_q;
  assign transaction_complete = tc_q;
  assign data_out             = dout_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized scoreboard bench for mem_responder: a LATENCY=4 and a LATENCY=1
// instance share the stimulus bus and are exercised one at a time. A byte
// array models storage; a queue carries expected completions to the monitor.
module tb_mem_responder;

  logic        cpu_clk = 1'b0;
  logic        rst     = 1'b1;
  logic [27:0] addr    = 28'd0;
  logic [1:0]  width   = 2'd0;
  logic [63:0] data_in = 64'd0;
  logic        rstrobe = 1'b0;
  logic        wstrobe = 1'b0;

  logic [63:0] dout4, dout1;
  logic        tc4, tc1, rdy4, rdy1;

  mem_responder #(.ADDR_BITS(10), .LATENCY(4)) dut4 (
    .cpu_clk (cpu_clk), .rst (rst), .addr (addr), .width (width),
    .data_in (data_in), .rstrobe (rstrobe), .wstrobe (wstrobe),
    .data_out (dout4), .transaction_complete (tc4), .ready (rdy4)
  );

  mem_responder #(.ADDR_BITS(10), .LATENCY(1)) dut1 (
    .cpu_clk (cpu_clk), .rst (rst), .addr (addr), .width (width),
    .data_in (data_in), .rstrobe (rstrobe), .wstrobe (wstrobe),
    .data_out (dout1), .transaction_complete (tc1), .ready (rdy1)
  );

  always #5 cpu_clk = ~cpu_clk;

  bit          cur_sel = 1'b0;
  int          cur_lat = 4;
  logic [63:0] cur_dout;
  logic        cur_tc, cur_ready;
  assign cur_dout  = cur_sel ? dout1 : dout4;
  assign cur_tc    = cur_sel ? tc1   : tc4;
  assign cur_ready = cur_sel ? rdy1  : rdy4;

  typedef struct {
    int          due;
    bit          is_rd;
    logic [63:0] data;
  } ent_t;

  ent_t        sb[$];
  int          cyc = 0;
  int          ok_edge = 0;
  int          total = 0;
  int          bad = 0;
  logic [63:0] exp_dout = 64'd0;
  logic [7:0]  mem_m [0:8191];
  bit          vld_m [0:8191];

  always @(posedge cpu_clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [1:0] w);
    return 1 << w;
  endfunction

  function automatic void model_write(input logic [27:0] a, input logic [1:0] w,
                                      input logic [63:0] d);
    int n = nbytes(w);
    int base = int'(a[12:0]) / n * n;
    for (int i = 0; i < n; i++) begin
      mem_m[base + i] = d[63 - 8*i -: 8];
      vld_m[base + i] = 1'b1;
    end
  endfunction

  function automatic logic [63:0] model_read(input logic [27:0] a, input logic [1:0] w);
    int n = nbytes(w);
    int base = int'(a[12:0]) / n * n;
    logic [63:0] d = 64'd0;
    for (int i = 0; i < n; i++) d[63 - 8*i -: 8] = mem_m[base + i];
    return d;
  endfunction

  function automatic logic [27:0] rnd_addr();
    logic [27:0] a;
    a = 28'($urandom_range(0, 127));
    a[27:13] = 15'($urandom);
    return a;
  endfunction

  // Monitor: match each completion pulse against the head of the scoreboard.
  always @(negedge cpu_clk) begin
    ent_t e;
    logic [63:0] exp;
    if (!rst) begin
      if (cur_tc) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_complete actual=1 expected=0 cyc=%0d", cyc);
        end else begin
          e = sb.pop_front();
          check("complete_cycle", 64'(cyc), 64'(e.due));
          exp = e.is_rd ? e.data : exp_dout;
          exp_dout = exp;
          check(e.is_rd ? "read_data" : "dout_hold_on_write", cur_dout, exp);
        end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        total++; bad++;
        $display("FAIL missing_complete actual=0 expected=1 due=%0d cyc=%0d", e.due, cyc);
      end
    end
  end

  // One cycle of stimulus; the model alone decides whether it is accepted.
  task automatic step(input bit rd, input bit wr, input logic [27:0] a, input logic [1:0] w,
                      input logic [63:0] d, input bit use_k, input logic [63:0] k);
    bit   exp_rdy;
    ent_t e;
    rstrobe = rd; wstrobe = wr; addr = a; width = w; data_in = d;
    exp_rdy = (cyc + 1 >= ok_edge);
    check("ready", 64'(cur_ready), 64'(exp_rdy));
    if (exp_rdy && (rd || wr)) begin
      e.due = cyc + cur_lat;
      if (wr) begin
        model_write(a, w, d);
        e.is_rd = 1'b0;
        e.data  = 64'd0;
      end else begin
        e.is_rd = 1'b1;
        e.data  = use_k ? k : model_read(a, w);
      end
      sb.push_back(e);
      ok_edge = cyc + 1 + cur_lat;
    end
    @(posedge cpu_clk); #1;
    rstrobe = 1'b0; wstrobe = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 28'd0, 2'd0, 64'd0, 1'b0, 64'd0);
  endtask

  task automatic issue(input bit rd, input bit wr, input logic [27:0] a, input logic [1:0] w,
                       input logic [63:0] d, input bit use_k, input logic [63:0] k);
    while (cyc + 1 < ok_edge) idle();
    step(rd, wr, a, w, d, use_k, k);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    exp_dout = 64'd0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_ready", 64'(cur_ready), 64'd0);
      check("rst_tc", 64'(cur_tc), 64'd0);
      check("rst_dout", cur_dout, 64'd0);
      @(posedge cpu_clk); #1;
    end
    rst = 1'b0;
    #1;
    check("ready_before_first_edge", 64'(cur_ready), 64'd0);
    ok_edge = cyc + 2;
  endtask

  task automatic init_region();
    for (int i = 0; i < 8192; i++) vld_m[i] = 1'b0;
    for (int i = 0; i < 16; i++)
      issue(1'b0, 1'b1, 28'(i * 8), 2'd3, {$urandom, $urandom}, 1'b0, 64'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) idle();
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL drain actual=%0d expected=0 pending", sb.size());
    end
  endtask

  initial begin
    int op;
    @(posedge cpu_clk); #1;
    // ---- LATENCY=4 instance ----
    cur_sel = 1'b0; cur_lat = 4;
    do_reset();
    issue(1'b0, 1'b1, 28'h10, 2'd3, 64'h0123_4567_89AB_CDEF, 1'b0, 64'd0);
    step(1'b1, 1'b0, 28'h10, 2'd3, 64'd0, 1'b0, 64'd0);  // strobe while busy
    issue(1'b1, 1'b0, 28'h10, 2'd1, 64'd0, 1'b1, 64'h0123_0000_0000_0000);
    issue(1'b0, 1'b1, 28'h13, 2'd0, 64'hAA00_0000_0000_0000, 1'b0, 64'd0);
    issue(1'b1, 1'b0, 28'h10, 2'd3, 64'd0, 1'b1, 64'h0123_45AA_89AB_CDEF);
    issue(1'b1, 1'b0, 28'h15, 2'd2, 64'd0, 1'b1, 64'h89AB_CDEF_0000_0000);
    issue(1'b1, 1'b0, 28'h2010, 2'd3, 64'd0, 1'b1, 64'h0123_45AA_89AB_CDEF);
    issue(1'b1, 1'b1, 28'h20, 2'd3, 64'h1122_3344_5566_7788, 1'b0, 64'd0);
    issue(1'b1, 1'b0, 28'h20, 2'd3, 64'd0, 1'b1, 64'h1122_3344_5566_7788);
    issue(1'b0, 1'b1, 28'h40, 2'd3, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 64'd0);
    idle();
    do_reset();  // aborts the write's completion; the data stays committed
    issue(1'b1, 1'b0, 28'h40, 2'd3, 64'd0, 1'b1, 64'hDEAD_BEEF_CAFE_F00D);
    init_region();
    for (int i = 0; i < 60; i++) begin
      op = int'($urandom % 8);
      case (op)
        0, 1, 2: issue(1'b1, 1'b0, rnd_addr(), 2'($urandom), 64'd0, 1'b0, 64'd0);
        3, 4, 5: issue(1'b0, 1'b1, rnd_addr(), 2'($urandom), {$urandom, $urandom}, 1'b0, 64'd0);
        6:       issue(1'b1, 1'b1, rnd_addr(), 2'($urandom), {$urandom, $urandom}, 1'b0, 64'd0);
        default: step(1'b1, 1'b0, rnd_addr(), 2'($urandom), 64'd0, 1'b0, 64'd0);
      endcase
    end
    drain();
    // ---- LATENCY=1 instance: back-to-back traffic every cycle ----
    cur_sel = 1'b1; cur_lat = 1;
    do_reset();
    init_region();
    for (int i = 0; i < 80; i++) begin
      op = int'($urandom % 6);
      case (op)
        0, 1: step(1'b1, 1'b0, rnd_addr(), 2'($urandom), 64'd0, 1'b0, 64'd0);
        2, 3: step(1'b0, 1'b1, rnd_addr(), 2'($urandom), {$urandom, $urandom}, 1'b0, 64'd0);
        4:    step(1'b1, 1'b1, rnd_addr(), 2'($urandom), {$urandom, $urandom}, 1'b0, 64'd0);
        default: idle();
      endcase
    end
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
